// File: rtl/sorted_dedup_pkg.sv
// Shared types for the sorted_dedup packet stage.
//   dedup_state_t : look-behind FSM state
//                   IDLE  - no word held
//                   HOLD  - one word held, waiting for the next word to compare against
//                   FLUSH - the held word is the last unique word of the packet; emit it with EOP
package sorted_dedup_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } dedup_state_t;

endpackage

// File: rtl/sorted_dedup_if.sv
// Avalon-ST style streaming bundle: data, SOP, EOP, valid and ready.
//   master modport : drives data/startofpacket/endofpacket/valid, receives ready
//   slave  modport : receives data/startofpacket/endofpacket/valid, drives ready
interface sorted_dedup_if #(
    parameter int DWIDTH = 8
) ();

    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output startofpacket,
        output endofpacket,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  startofpacket,
        input  endofpacket,
        input  valid,
        output ready
    );

endinterface

// File: rtl/sorted_dedup.sv
// Removes adjacent duplicate words from sorted Avalon-ST packets.
// One word of look-behind is held; a held word is emitted once the next word
// differs from it, or when EOP arrives. The output beat is registered.
// Ports:
//   clk_i      : clock
//   srst_i     : synchronous reset, active-high
//   snk        : sink stream (slave), snk.ready is combinational
//   src        : source stream (master), fully registered
//   drop_cnt_o : duplicates dropped from the last completed packet, saturating at MAX_PKT_LEN
//   err_o      : one-cycle pulse on a framing error (beat without SOP in IDLE, or SOP inside a packet)
module sorted_dedup
    import sorted_dedup_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic                             clk_i,
    input  logic                             srst_i,
    sorted_dedup_if.slave                    snk,
    sorted_dedup_if.master                   src,
    output logic [$clog2(MAX_PKT_LEN+1)-1:0] drop_cnt_o,
    output logic                             err_o
);

    localparam int                CWIDTH  = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CWIDTH-1:0] CNT_MAX = CWIDTH'(MAX_PKT_LEN);

    dedup_state_t      r_state;
    dedup_state_t      w_state_nxt;

    logic [DWIDTH-1:0] r_hold_data;
    logic              r_hold_sop;
    logic [CWIDTH-1:0] r_drop_cnt;
    logic [CWIDTH-1:0] r_drop_cnt_o;
    logic              r_err;

    logic [DWIDTH-1:0] r_src_data;
    logic              r_src_sop;
    logic              r_src_eop;
    logic              r_src_valid;

    logic              w_out_free;
    logic              w_snk_ready;
    logic              w_acc;
    logic              w_same;
    logic              w_start;
    logic [CWIDTH-1:0] w_cnt_inc;

    logic              w_emit;
    logic [DWIDTH-1:0] w_emit_data;
    logic              w_emit_sop;
    logic              w_emit_eop;
    logic              w_load_hold;
    logic              w_hold_sop_nxt;
    logic [CWIDTH-1:0] w_drop_cnt_nxt;
    logic              w_upd_cnt_o;
    logic [CWIDTH-1:0] w_cnt_o_nxt;
    logic              w_err;

    // The output register can take a new beat when empty or draining this cycle.
    assign w_out_free  = !r_src_valid || src.ready;
    assign w_snk_ready = w_out_free && (r_state != FLUSH);
    assign w_acc       = snk.valid && w_snk_ready;
    assign w_same      = (snk.data == r_hold_data);
    assign w_cnt_inc   = (r_drop_cnt >= CNT_MAX) ? r_drop_cnt : r_drop_cnt + 1'b1;

    // SOP opens a packet in IDLE and restarts one in HOLD; FLUSH never accepts.
    assign w_start     = w_acc && snk.startofpacket;

    always_comb begin
        w_state_nxt    = r_state;
        w_emit         = 1'b0;
        w_emit_data    = r_hold_data;
        w_emit_sop     = r_hold_sop;
        w_emit_eop     = 1'b0;
        w_load_hold    = 1'b0;
        w_hold_sop_nxt = 1'b0;
        w_drop_cnt_nxt = r_drop_cnt;
        w_upd_cnt_o    = 1'b0;
        w_cnt_o_nxt    = r_drop_cnt;
        w_err          = 1'b0;

        if (w_start) begin
            // A SOP seen while a word is held means the previous packet lost its EOP.
            w_err          = (r_state == HOLD);
            w_drop_cnt_nxt = '0;
            if (snk.endofpacket) begin
                w_emit      = 1'b1;
                w_emit_data = snk.data;
                w_emit_sop  = 1'b1;
                w_emit_eop  = 1'b1;
                w_upd_cnt_o = 1'b1;
                w_cnt_o_nxt = '0;
                w_state_nxt = IDLE;
            end else begin
                w_load_hold    = 1'b1;
                w_hold_sop_nxt = 1'b1;
                w_state_nxt    = HOLD;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        w_err = 1'b1;
                    end
                end
                HOLD: begin
                    if (w_acc) begin
                        if (w_same) begin
                            if (snk.endofpacket) begin
                                w_emit      = 1'b1;
                                w_emit_eop  = 1'b1;
                                w_upd_cnt_o = 1'b1;
                                w_cnt_o_nxt = w_cnt_inc;
                                w_state_nxt = IDLE;
                            end else begin
                                w_drop_cnt_nxt = w_cnt_inc;
                            end
                        end else begin
                            w_emit      = 1'b1;
                            w_load_hold = 1'b1;
                            if (snk.endofpacket) begin
                                w_state_nxt = FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (w_out_free) begin
                        w_emit      = 1'b1;
                        w_emit_sop  = 1'b0;
                        w_emit_eop  = 1'b1;
                        w_upd_cnt_o = 1'b1;
                        w_cnt_o_nxt = r_drop_cnt;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state      <= IDLE;
            r_hold_data  <= '0;
            r_hold_sop   <= 1'b0;
            r_drop_cnt   <= '0;
            r_drop_cnt_o <= '0;
            r_err        <= 1'b0;
            r_src_data   <= '0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_src_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
            r_err      <= w_err;
            if (w_load_hold) begin
                r_hold_data <= snk.data;
                r_hold_sop  <= w_hold_sop_nxt;
            end
            if (w_upd_cnt_o) begin
                r_drop_cnt_o <= w_cnt_o_nxt;
            end
            if (w_emit) begin
                r_src_valid <= 1'b1;
                r_src_data  <= w_emit_data;
                r_src_sop   <= w_emit_sop;
                r_src_eop   <= w_emit_eop;
            end else if (src.ready) begin
                r_src_valid <= 1'b0;
            end
        end
    end

    assign snk.ready         = w_snk_ready;
    assign src.valid         = r_src_valid;
    assign src.data          = r_src_data;
    assign src.startofpacket = r_src_sop;
    assign src.endofpacket   = r_src_eop;
    assign drop_cnt_o        = r_drop_cnt_o;
    assign err_o             = r_err;

endmodule

// File: tb/tb_sorted_dedup.sv
// Self-checking bench for sorted_dedup: directed packets plus random sorted
// packets under random backpressure, checked against a queue-based model.
module tb_sorted_dedup;

    localparam int DW   = 8;
    localparam int MAXL = 16;
    localparam int CW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          srst;
    logic [CW-1:0] drop_cnt;
    logic          err;

    always #5 clk = ~clk;

    sorted_dedup_if #(.DWIDTH(DW)) snk ();
    sorted_dedup_if #(.DWIDTH(DW)) src ();

    sorted_dedup #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .snk        (snk),
        .src        (src),
        .drop_cnt_o (drop_cnt),
        .err_o      (err)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t obs_q[$];
    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   err_seen = 0;
    int   stab_viol = 0;
    bit   bp_mode = 1'b0;

    bit            held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_sop, held_eop;

    // Source ready: always 1, or random when backpressure is enabled.
    initial begin
        src.ready = 1'b1;
        forever begin
            @(negedge clk);
            src.ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: records transferred beats, err pulses and stalled-beat stability.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (srst) begin
                held_v = 1'b0;
            end else begin
                if (held_v && !(src.valid && src.data == held_d &&
                                src.startofpacket == held_sop && src.endofpacket == held_eop))
                    stab_viol++;
                held_v   = src.valid && !src.ready;
                held_d   = src.data;
                held_sop = src.startofpacket;
                held_eop = src.endofpacket;
                if (src.valid && src.ready)
                    obs_q.push_back('{src.data, src.startofpacket, src.endofpacket, drop_cnt});
                if (err)
                    err_seen++;
            end
        end
    end

    // Reference: a sorted packet reduces to its distinct values; drops = len - distinct, saturated.
    function automatic void model_pkt(input logic [DW-1:0] pkt[$]);
        logic [DW-1:0] u[$];
        int            drops;
        foreach (pkt[i])
            if (i == 0 || pkt[i] != pkt[i-1])
                u.push_back(pkt[i]);
        drops = pkt.size() - u.size();
        if (drops > MAXL)
            drops = MAXL;
        foreach (u[j])
            exp_q.push_back('{u[j], j == 0, j == u.size() - 1, CW'(drops)});
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input bit sop, input bit eop, input bit gaps);
        int g;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            snk.valid = 1'b0;
        end
        @(negedge clk);
        snk.valid         = 1'b1;
        snk.data          = d;
        snk.startofpacket = sop;
        snk.endofpacket   = eop;
        #1;
        g = 0;
        while (!snk.ready && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 50) begin
            total++;
            bad++;
            $display("FAIL sink_accept_timeout got=ready_low exp=ready within 50 cycles");
        end
    endtask

    task automatic send_pkt(input logic [DW-1:0] pkt[$], input bit gaps);
        foreach (pkt[i])
            send_beat(pkt[i], i == 0, i == pkt.size() - 1, gaps);
    endtask

    task automatic idle_sink();
        @(negedge clk);
        snk.valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int g = 0;
        while (obs_q.size() < n && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        snk.valid = 1'b0;
        snk.data = '0;
        snk.startofpacket = 1'b0;
        snk.endofpacket = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({src.valid, src.startofpacket, src.endofpacket, src.data, drop_cnt, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%b/%h/%0d/%b exp=all zero",
                     src.valid, src.startofpacket, src.endofpacket, src.data, drop_cnt, err);
        end
        total++;
        if (snk.ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", snk.ready);
        end
        srst = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_unique();
        logic [DW-1:0] p[$];
        p = '{8'd1, 8'd2, 8'd3, 8'd4};
        obs_q.delete(); exp_q.delete();
        model_pkt(p);
        send_pkt(p, 1'b0);
        idle_sink();
        #1;
        total++;
        if (snk.ready !== 1'b0) begin
            bad++;
            $display("FAIL unique_stall got=%b exp=0", snk.ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (snk.ready !== 1'b1) begin
            bad++;
            $display("FAIL unique_after_stall got=%b exp=1", snk.ready);
        end
        drain(exp_q.size());
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL unique_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if ({obs_q[i].d, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].d, exp_q[i].sop, exp_q[i].eop}) begin
                bad++;
                $display("FAIL unique_beat%0d got=%h/%b%b exp=%h/%b%b", i, obs_q[i].d, obs_q[i].sop,
                         obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
            end
            if (exp_q[i].eop) begin
                total++;
                if (obs_q[i].cnt !== exp_q[i].cnt) begin
                    bad++;
                    $display("FAIL unique_drop got=%0d exp=%0d", obs_q[i].cnt, exp_q[i].cnt);
                end
            end
        end
    endtask

    task automatic test_dups();
        logic [DW-1:0] p[$];
        p = '{8'd5, 8'd5, 8'd5, 8'd7, 8'd7};
        obs_q.delete(); exp_q.delete();
        model_pkt(p);
        send_pkt(p, 1'b0);
        idle_sink();
        #1;
        total++;
        if (snk.ready !== 1'b1) begin
            bad++;
            $display("FAIL dups_no_stall got=%b exp=1", snk.ready);
        end
        drain(exp_q.size());
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL dups_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if ({obs_q[i].d, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].d, exp_q[i].sop, exp_q[i].eop}) begin
                bad++;
                $display("FAIL dups_beat%0d got=%h/%b%b exp=%h/%b%b", i, obs_q[i].d, obs_q[i].sop,
                         obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
            end
            if (exp_q[i].eop) begin
                total++;
                if (obs_q[i].cnt !== exp_q[i].cnt) begin
                    bad++;
                    $display("FAIL dups_drop got=%0d exp=%0d", obs_q[i].cnt, exp_q[i].cnt);
                end
            end
        end
    endtask

    task automatic test_single();
        obs_q.delete();
        send_beat(8'd9, 1'b1, 1'b1, 1'b0);
        idle_sink();
        #1;
        total++;
        if ({src.valid, src.data, src.startofpacket, src.endofpacket, drop_cnt} !==
            {1'b1, 8'd9, 1'b1, 1'b1, CW'(0)}) begin
            bad++;
            $display("FAIL single_beat got=%b/%h/%b%b/%0d exp=1/09/11/0", src.valid, src.data,
                     src.startofpacket, src.endofpacket, drop_cnt);
        end
        drain(1);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d exp=1", obs_q.size());
        end
    endtask

    task automatic test_all_same();
        logic [DW-1:0] p[$];
        p = '{8'd3, 8'd3, 8'd3, 8'd3};
        obs_q.delete(); exp_q.delete();
        model_pkt(p);
        send_pkt(p, 1'b0);
        idle_sink();
        drain(exp_q.size());
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL same_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL same_beat%0d got=%h/%b%b/%0d exp=%h/%b%b/%0d", i, obs_q[i].d, obs_q[i].sop,
                         obs_q[i].eop, obs_q[i].cnt, exp_q[i].d, exp_q[i].sop, exp_q[i].eop, exp_q[i].cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] p[$];
        p = '{8'd1, 8'd2, 8'd2, 8'd8};
        obs_q.delete(); exp_q.delete();
        stab_viol = 0;
        bp_mode = 1'b1;
        repeat (4) begin
            model_pkt(p);
            send_pkt(p, 1'b1);
        end
        idle_sink();
        drain(exp_q.size());
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if ({obs_q[i].d, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].d, exp_q[i].sop, exp_q[i].eop}) begin
                bad++;
                $display("FAIL bp_beat%0d got=%h/%b%b exp=%h/%b%b", i, obs_q[i].d, obs_q[i].sop,
                         obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
            end
            if (exp_q[i].eop) begin
                total++;
                if (obs_q[i].cnt !== exp_q[i].cnt) begin
                    bad++;
                    $display("FAIL bp_drop got=%0d exp=%0d", obs_q[i].cnt, exp_q[i].cnt);
                end
            end
        end
        total++;
        if (stab_viol != 0) begin
            bad++;
            $display("FAIL bp_stability got=%0d changes exp=0", stab_viol);
        end
    endtask

    task automatic test_restart();
        int e0;
        obs_q.delete();
        e0 = err_seen;
        send_beat(8'd4, 1'b1, 1'b0, 1'b0);
        send_beat(8'd6, 1'b0, 1'b0, 1'b0);
        send_beat(8'd2, 1'b1, 1'b1, 1'b0);
        idle_sink();
        drain(2);
        total++;
        if (err_seen - e0 != 1) begin
            bad++;
            $display("FAIL restart_err got=%0d pulses exp=1", err_seen - e0);
        end
        total++;
        if (obs_q.size() != 2) begin
            bad++;
            $display("FAIL restart_count got=%0d exp=2", obs_q.size());
        end else begin
            total++;
            if ({obs_q[0].d, obs_q[0].sop, obs_q[0].eop} !== {8'd4, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL restart_first got=%h/%b%b exp=04/10", obs_q[0].d, obs_q[0].sop, obs_q[0].eop);
            end
            total++;
            if (obs_q[1] !== obs_t'{8'd2, 1'b1, 1'b1, CW'(0)}) begin
                bad++;
                $display("FAIL restart_second got=%h/%b%b/%0d exp=02/11/0", obs_q[1].d, obs_q[1].sop,
                         obs_q[1].eop, obs_q[1].cnt);
            end
        end
    endtask

    task automatic test_no_sop();
        int e0;
        obs_q.delete();
        e0 = err_seen;
        send_beat(8'd7, 1'b0, 1'b1, 1'b0);
        idle_sink();
        repeat (4) @(negedge clk);
        total++;
        if (err_seen - e0 != 1 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL nosop got=%0d pulses/%0d beats exp=1/0", err_seen - e0, obs_q.size());
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] p[$];
        for (int i = 0; i < 20; i++)
            p.push_back(8'h11);
        obs_q.delete(); exp_q.delete();
        model_pkt(p);
        send_pkt(p, 1'b0);
        idle_sink();
        drain(1);
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL saturate got=%0d beats cnt=%0d exp=1 beat cnt=%0d", obs_q.size(),
                     (obs_q.size() > 0) ? int'(obs_q[0].cnt) : -1, exp_q[0].cnt);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] p[$];
        int            v;
        int            e0;
        obs_q.delete(); exp_q.delete();
        e0 = err_seen;
        bp_mode = 1'b1;
        for (int k = 0; k < 30; k++) begin
            p.delete();
            v = $urandom_range(0, 40);
            for (int n = $urandom_range(1, MAXL); n > 0; n--) begin
                p.push_back(DW'(v));
                v += $urandom_range(0, 2);
            end
            model_pkt(p);
            send_pkt(p, 1'b1);
        end
        idle_sink();
        drain(exp_q.size());
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if ({obs_q[i].d, obs_q[i].sop, obs_q[i].eop} !== {exp_q[i].d, exp_q[i].sop, exp_q[i].eop}) begin
                bad++;
                $display("FAIL rand_beat%0d got=%h/%b%b exp=%h/%b%b", i, obs_q[i].d, obs_q[i].sop,
                         obs_q[i].eop, exp_q[i].d, exp_q[i].sop, exp_q[i].eop);
            end
            if (exp_q[i].eop) begin
                total++;
                if (obs_q[i].cnt !== exp_q[i].cnt) begin
                    bad++;
                    $display("FAIL rand_drop%0d got=%0d exp=%0d", i, obs_q[i].cnt, exp_q[i].cnt);
                end
            end
        end
        total++;
        if (err_seen != e0) begin
            bad++;
            $display("FAIL rand_err got=%0d pulses exp=0", err_seen - e0);
        end
    endtask

    task automatic test_reset_mid();
        send_beat(8'd4, 1'b1, 1'b0, 1'b0);
        send_beat(8'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        srst = 1'b1;
        snk.valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({src.valid, snk.ready, drop_cnt} !== {1'b0, 1'b1, CW'(0)}) begin
            bad++;
            $display("FAIL midreset got=valid%b ready%b cnt%0d exp=valid0 ready1 cnt0",
                     src.valid, snk.ready, drop_cnt);
        end
        srst = 1'b0;
        obs_q.delete();
        repeat (6) @(negedge clk);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_stray got=%0d beats exp=0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_unique();
        test_dups();
        test_single();
        test_all_same();
        test_backpressure();
        test_restart();
        test_no_sop();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
